// File: rtl/imem_dump_reader.sv
// imem_dump_reader: debug readback engine for the instruction memory.
// On an accepted start it walks the inclusive range first_addr..last_addr, issues one read per
// address and serialises each 16-bit word as two bytes (high byte first) on a valid/ready stream.
//
// Optional feature: define IMEM_DUMP_CHECKSUM_EN to append an 8-bit XOR checksum of all
// transferred data bytes as one extra byte after the last word.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               one-cycle dump request, sampled only when idle
//   first_addr          first address to dump, latched on accepted start
//   last_addr           last address to dump (inclusive), latched on accepted start
//   busy                high from the cycle after accepted start through the done cycle
//   done                one-cycle pulse after the final byte is transferred
//   err                 one-cycle pulse when start is rejected (first_addr > last_addr)
//   mem_addr, mem_re    instruction memory read address / read enable (one cycle per word)
//   mem_rdata           read data, valid READ_LAT cycles after mem_re
//   tx_data, tx_valid   byte stream out
//   tx_ready            sink ready; a byte moves on an edge with tx_valid && tx_ready
module imem_dump_reader #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [15:0]       mem_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StRead   = 3'd1;
    localparam logic [2:0] StWait   = 3'd2;
    localparam logic [2:0] StSendHi = 3'd3;
    localparam logic [2:0] StSendLo = 3'd4;
    localparam logic [2:0] StDone   = 3'd5;
`ifdef IMEM_DUMP_CHECKSUM_EN
    localparam logic [2:0] StCksum  = 3'd6;
`endif

    // Wait-state index on which mem_rdata is valid.
    localparam logic [1:0] WaitLast = 2'(READ_LAT - 1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [15:0]       word_q, word_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              xfer;
`ifdef IMEM_DUMP_CHECKSUM_EN
    logic [7:0]        cksum_q, cksum_d;
`endif

    assign xfer = tx_valid && tx_ready;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        last_d  = last_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`ifdef IMEM_DUMP_CHECKSUM_EN
        cksum_d = cksum_q;
        if (xfer && state_q != StCksum) begin
            cksum_d = cksum_q ^ tx_data;
        end
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    if (first_addr <= last_addr) begin
                        cur_d   = first_addr;
                        last_d  = last_addr;
                        state_d = StRead;
`ifdef IMEM_DUMP_CHECKSUM_EN
                        cksum_d = 8'h00;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StRead: begin
                cnt_d   = 2'd0;
                state_d = StWait;
            end
            StWait: begin
                if (cnt_q == WaitLast) begin
                    word_d  = mem_rdata;
                    state_d = StSendHi;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            StSendHi: begin
                if (tx_ready) begin
                    state_d = StSendLo;
                end
            end
            StSendLo: begin
                if (tx_ready) begin
                    // Compare before incrementing so the top address never wraps to 0.
                    if (cur_q == last_q) begin
`ifdef IMEM_DUMP_CHECKSUM_EN
                        state_d = StCksum;
`else
                        state_d = StDone;
`endif
                    end else begin
                        cur_d   = cur_q + 1'b1;
                        state_d = StRead;
                    end
                end
            end
`ifdef IMEM_DUMP_CHECKSUM_EN
            StCksum: begin
                if (tx_ready) begin
                    state_d = StDone;
                end
            end
`endif
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cur_q   <= '0;
            last_q  <= '0;
            word_q  <= 16'h0000;
            cnt_q   <= 2'd0;
            err_q   <= 1'b0;
`ifdef IMEM_DUMP_CHECKSUM_EN
            cksum_q <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`ifdef IMEM_DUMP_CHECKSUM_EN
            cksum_q <= cksum_d;
`endif
        end
    end

    always_comb begin
        busy     = (state_q != StIdle);
        done     = (state_q == StDone);
        err      = err_q;
        mem_re   = (state_q == StRead);
        // cur_q only changes on the edge into READ, so the address holds between reads.
        mem_addr = cur_q;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (state_q)
            StSendHi: begin
                tx_valid = 1'b1;
                tx_data  = word_q[15:8];
            end
            StSendLo: begin
                tx_valid = 1'b1;
                tx_data  = word_q[7:0];
            end
`ifdef IMEM_DUMP_CHECKSUM_EN
            StCksum: begin
                tx_valid = 1'b1;
                tx_data  = cksum_q;
            end
`endif
            default: begin
                tx_valid = 1'b0;
                tx_data  = 8'h00;
            end
        endcase
    end

endmodule

// File: tb/tb_imem_dump_reader.sv
// Bench for imem_dump_reader: a queue-based model of expected reads and bytes is checked every
// cycle by one monitor process; directed scenarios add literal cycle and byte expectations.
module tb_imem_dump_reader;

`ifdef IMEM_DUMP_CHECKSUM_EN
    localparam int CkExtra = 1;
`else
    localparam int CkExtra = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  first_addr = 8'h00;
    logic [7:0]  last_addr = 8'h00;
    logic        busy, done, err, mem_re, tx_valid;
    logic [7:0]  mem_addr, tx_data;
    logic [15:0] mem_rdata = 16'h0000;
    logic        tx_ready = 1'b1;

    imem_dump_reader #(.ADDR_W(8), .READ_LAT(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready)
    );

    always #5 clk = ~clk;

    // Instruction memory with one cycle read latency.
    logic [15:0] mem [256];
    always @(posedge clk) if (mem_re) mem_rdata <= mem[mem_addr];

    int pcyc = 0;
    always @(posedge clk) pcyc <= pcyc + 1;

    int total = 0;
    int bad = 0;
    int p0 = 0;
    int done_cyc = -1;
    logic [7:0] exp_addrs[$];
    logic [7:0] exp_bytes[$];
    logic [7:0] byte_log[$];
    int         re_log[$];
    logic [7:0] ref_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Expected reads and bytes for a range, derived directly from the memory contents.
    task automatic model_load(input int f, input int l);
        logic [7:0] ck;
        ck = 8'h00;
        for (int a = f; a <= l; a++) begin
            exp_addrs.push_back(8'(a));
            exp_bytes.push_back(mem[a][15:8]);
            exp_bytes.push_back(mem[a][7:0]);
            ck = ck ^ mem[a][15:8] ^ mem[a][7:0];
        end
        if (CkExtra == 1) exp_bytes.push_back(ck);
    endtask

    // Monitor: checks every read and every transferred byte against the model.
    initial begin
        logic       hold;
        logic [7:0] hold_data;
        hold = 1'b0;
        hold_data = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("hold_valid", 32'(tx_valid), 32'd1);
                    chk("hold_data", 32'(tx_data), 32'(hold_data));
                end
                if (mem_re) begin
                    re_log.push_back(pcyc - p0 + 1);
                    if (exp_addrs.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_read: addr %0h, none expected", mem_addr);
                    end else begin
                        chk("read_addr", 32'(mem_addr), 32'(exp_addrs.pop_front()));
                    end
                end
                if (tx_valid && tx_ready) begin
                    byte_log.push_back(tx_data);
                    if (exp_bytes.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_byte: got %0h, none expected", tx_data);
                    end else begin
                        chk("byte", 32'(tx_data), 32'(exp_bytes.pop_front()));
                    end
                end
                if (done) begin
                    done_cyc = pcyc - p0 + 1;
                    chk("done_drained", 32'(exp_bytes.size() + exp_addrs.size()), 32'd0);
                    chk("done_busy", 32'(busy), 32'd1);
                end
                hold = tx_valid && !tx_ready;
                hold_data = tx_data;
            end
        end
    end

    // Drives a start pulse; returns #1 into cycle 1 (edge 0 is the accepting edge).
    task automatic start_dump(input int f, input int l);
        @(posedge clk);
        #1;
        start = 1'b1;
        first_addr = 8'(f);
        last_addr = 8'(l);
        byte_log.delete();
        re_log.delete();
        done_cyc = -1;
        if (f <= l) model_load(f, l);
        @(posedge clk);
        #1;
        start = 1'b0;
        p0 = pcyc;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < budget);
        if (!done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_log(input string name);
        chk({name, "_count"}, 32'(byte_log.size()), 32'(ref_q.size()));
        for (int i = 0; i < ref_q.size() && i < byte_log.size(); i++) begin
            chk(name, 32'(byte_log[i]), 32'(ref_q[i]));
        end
    endtask

    task automatic outputs_zero(input string name);
        chk(name, {11'd0, busy, done, err, mem_re, tx_valid, mem_addr, tx_data}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {8'(i), ~8'(i)};
        mem[0] = 16'h4810;
        mem[1] = 16'h4A12;
        mem[2] = 16'h4C14;
        mem[254] = 16'hA1B2;
        mem[255] = 16'hC3D4;

        repeat (2) @(negedge clk);
        outputs_zero("reset_outputs");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: three-word dump, full-rate sink.
        start_dump(0, 2);
        wait_done(100);
        chk("s1_busy_in_done", 32'(busy), 32'd1);
        ref_q = '{8'h48, 8'h10, 8'h4A, 8'h12, 8'h4C, 8'h14};
        if (CkExtra == 1) ref_q.push_back(8'h58);
        check_log("s1_bytes");
        chk("s1_re_count", 32'(re_log.size()), 32'd3);
        for (int i = 0; i < 3 && i < re_log.size(); i++) begin
            chk("s1_re_cycle", 32'(re_log[i]), 32'(1 + 4 * i));
        end
        chk("s1_done_cycle", 32'(done_cyc), 32'(13 + CkExtra));
        @(negedge clk);
        chk("s1_busy_after", 32'(busy), 32'd0);

        // 2: backpressure during the high byte.
        tx_ready = 1'b0;
        start_dump(0, 0);
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!tx_valid && n < 20);
        end
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            chk("s2_stall_valid", 32'(tx_valid), 32'd1);
            chk("s2_stall_data", 32'(tx_data), 32'h48);
        end
        @(posedge clk);
        #1;
        tx_ready = 1'b1;
        wait_done(50);
        ref_q = '{8'h48, 8'h10};
        if (CkExtra == 1) ref_q.push_back(8'h58);
        check_log("s2_bytes");

        // 3: reversed range is rejected.
        repeat (2) @(posedge clk);
        start_dump(5, 2);
        chk("s3_err", 32'(err), 32'd1);
        chk("s3_busy", 32'(busy), 32'd0);
        chk("s3_mem_re", 32'(mem_re), 32'd0);
        chk("s3_tx_valid", 32'(tx_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("s3_err_pulse", 32'(err), 32'd0);
        chk("s3_busy_after", 32'(busy), 32'd0);

        // 4: range ending at the top address.
        start_dump(254, 255);
        wait_done(100);
        ref_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        if (CkExtra == 1) ref_q.push_back(8'h04);
        check_log("s4_bytes");
        repeat (4) @(negedge clk);
        chk("s4_re_count", 32'(re_log.size()), 32'd2);
        chk("s4_busy_after", 32'(busy), 32'd0);

        // 5: reset during the second word's low byte, then a fresh dump.
        start_dump(0, 2);
        repeat (7) @(posedge clk);
        #1;
        chk("s5_in_send_lo", {23'd0, tx_valid, tx_data}, 32'h112);
        rst_n = 1'b0;
        #1;
        outputs_zero("s5_reset_outputs");
        exp_addrs.delete();
        exp_bytes.delete();
        ref_q = '{8'h48, 8'h10, 8'h4A};
        check_log("s5_before_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("s5_idle_after_release", 32'(busy), 32'd0);
        start_dump(1, 1);
        wait_done(50);
        ref_q = '{8'h4A, 8'h12};
        if (CkExtra == 1) ref_q.push_back(8'h58);
        check_log("s5_bytes");

        // 6: start pulses while busy, including the done cycle, are ignored.
        start_dump(0, 2);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        first_addr = 8'd5;
        last_addr = 8'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(100);
        start = 1'b1;
        first_addr = 8'd0;
        last_addr = 8'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("s6_busy_after", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        ref_q = '{8'h48, 8'h10, 8'h4A, 8'h12, 8'h4C, 8'h14};
        if (CkExtra == 1) ref_q.push_back(8'h58);
        check_log("s6_bytes");
        chk("s6_done_cycle", 32'(done_cyc), 32'(13 + CkExtra));
        chk("s6_re_count", 32'(re_log.size()), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
